// File: rtl/test_xif_pkg.sv
// Shared types and helpers for the X-IF compressed-request scheduler.
// The req/resp structs use the same layout as the ibex_pkg compressed-interface types.
package test_xif_pkg;

    typedef enum logic [1:0] {IDLE, PROBE, RESP} xif_sched_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [1:0]  mode;
        logic [3:0]  id;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    // $clog2 clamped to at least one bit, so single-entry cases still get a usable vector.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a decoder index.
    function automatic int unsigned copro_idx_w(input int unsigned num_copro);
        return clog2_min1(num_copro);
    endfunction

endpackage

// File: rtl/test_xif_wait_timer.sv
// Saturating wait counter with clear/enable; expired_o flags the last allowed wait cycle.
module test_xif_wait_timer
    import test_xif_pkg::*;
#(
    parameter int unsigned MaxWait = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = clog2_min1(MaxWait);
    localparam logic [CntW-1:0] LastCnt = CntW'(MaxWait - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    // Next count: clear wins, otherwise count up and hold at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/test_xif_compressed_scheduler.sv
// Offers one core X-IF compressed request to NumCopro decoders in turn; the first
// accepting decoder supplies the response, otherwise the core sees accept=0.
// Optional: TEST_XIF_COMP_LAST_HIT_EN starts probing at the most recent accepting decoder.
module test_xif_compressed_scheduler
    import test_xif_pkg::*;
#(
    parameter int unsigned NumCopro = 2,
    parameter int unsigned MaxWait  = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                x_compressed_valid_i,
    output logic                                x_compressed_ready_o,
    input  x_compressed_req_t                   x_compressed_req_i,
    output x_compressed_resp_t                  x_compressed_resp_o,
    output logic [NumCopro-1:0]                 cop_valid_o,
    input  logic [NumCopro-1:0]                 cop_ready_i,
    output x_compressed_req_t                   cop_req_o,
    input  x_compressed_resp_t [NumCopro-1:0]   cop_resp_i
);

    localparam int unsigned IdxW = copro_idx_w(NumCopro);
    localparam int unsigned CntW = $clog2(NumCopro + 1);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumCopro - 1);
    localparam logic [CntW-1:0] LastProbe = CntW'(NumCopro - 1);

    xif_sched_state_e   state_d, state_q;
    logic [IdxW-1:0]    idx_d, idx_q;
    logic [CntW-1:0]    probed_d, probed_q;
    x_compressed_req_t  req_d, req_q;
    x_compressed_resp_t resp_d, resp_q;
    logic [IdxW-1:0]    start_idx;
    logic               timer_clear, timer_en, timer_expired;
    logic               sel_ready;
    x_compressed_resp_t sel_resp;

`ifdef TEST_XIF_COMP_LAST_HIT_EN
    logic [IdxW-1:0] last_hit_d, last_hit_q;
    assign start_idx = last_hit_q;
`else
    assign start_idx = '0;
`endif

    // Only the currently selected decoder is observed.
    assign sel_ready = cop_ready_i[idx_q];
    assign sel_resp  = cop_resp_i[idx_q];

    test_xif_wait_timer #(
        .MaxWait (MaxWait)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (timer_clear),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // Next-state and output decode for the probe sequencer.
    always_comb begin
        state_d              = state_q;
        idx_d                = idx_q;
        probed_d             = probed_q;
        req_d                = req_q;
        resp_d               = resp_q;
        timer_clear          = 1'b0;
        timer_en             = 1'b0;
        cop_valid_o          = '0;
        cop_req_o            = '0;
        x_compressed_ready_o = 1'b0;
        x_compressed_resp_o  = '0;
`ifdef TEST_XIF_COMP_LAST_HIT_EN
        last_hit_d           = last_hit_q;
`endif
        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (x_compressed_valid_i) begin
                    req_d    = x_compressed_req_i;
                    idx_d    = start_idx;
                    probed_d = '0;
                    state_d  = PROBE;
                end
            end
            PROBE: begin
                cop_valid_o[idx_q] = 1'b1;
                cop_req_o          = req_q;
                if (!x_compressed_valid_i) begin
                    // Core flushed the request: abandon without a response.
                    state_d = IDLE;
                end else if (sel_ready && sel_resp.accept) begin
                    resp_d  = sel_resp;
                    state_d = RESP;
`ifdef TEST_XIF_COMP_LAST_HIT_EN
                    last_hit_d = idx_q;
`endif
                end else if (sel_ready || timer_expired) begin
                    // Explicit reject or timeout: move to the next decoder.
                    timer_clear = 1'b1;
                    idx_d       = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                    probed_d    = probed_q + 1'b1;
                    if (probed_q == LastProbe) begin
                        resp_d  = '0;
                        state_d = RESP;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            RESP: begin
                x_compressed_ready_o = 1'b1;
                x_compressed_resp_o  = resp_q;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            probed_q   <= '0;
            req_q      <= '0;
            resp_q     <= '0;
`ifdef TEST_XIF_COMP_LAST_HIT_EN
            last_hit_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            probed_q   <= probed_d;
            req_q      <= req_d;
            resp_q     <= resp_d;
`ifdef TEST_XIF_COMP_LAST_HIT_EN
            last_hit_q <= last_hit_d;
`endif
        end
    end

endmodule

// File: tb/tb_test_xif_compressed_scheduler.sv
// Directed bench for test_xif_compressed_scheduler (NumCopro=2, MaxWait=4).
module tb_test_xif_compressed_scheduler;
    import test_xif_pkg::*;

    logic                            clk_i;
    logic                            rst_ni;
    logic                            x_compressed_valid_i;
    logic                            x_compressed_ready_o;
    x_compressed_req_t               x_compressed_req_i;
    x_compressed_resp_t              x_compressed_resp_o;
    logic [1:0]                      cop_valid_o;
    logic [1:0]                      cop_ready_i;
    x_compressed_req_t               cop_req_o;
    x_compressed_resp_t [1:0]        cop_resp_i;

    int checks;
    int errors;

    test_xif_compressed_scheduler #(
        .NumCopro (2),
        .MaxWait  (4)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .x_compressed_valid_i (x_compressed_valid_i),
        .x_compressed_ready_o (x_compressed_ready_o),
        .x_compressed_req_i   (x_compressed_req_i),
        .x_compressed_resp_o  (x_compressed_resp_o),
        .cop_valid_o          (cop_valid_o),
        .cop_ready_i          (cop_ready_i),
        .cop_req_o            (cop_req_o),
        .cop_resp_i           (cop_resp_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        x_compressed_valid_i = 1'b0;
        #12;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic set_dec(input logic [1:0] rdy, input logic [31:0] i0, input logic a0,
                           input logic [31:0] i1, input logic a1);
        cop_ready_i   = rdy;
        cop_resp_i[0] = '{instr: i0, accept: a0};
        cop_resp_i[1] = '{instr: i1, accept: a1};
    endtask

    initial begin
        checks = 0;
        errors = 0;
        x_compressed_req_i = '{instr: 16'h0085, mode: 2'b11, id: 4'h5};
        set_dec(2'b11, 32'h0, 1'b0, 32'h0, 1'b0);
        rst_ni = 1'b0;
        x_compressed_valid_i = 1'b0;
        #3;
        check("rst_ready", {31'b0, x_compressed_ready_o}, 32'h0);
        check("rst_valid", {30'b0, cop_valid_o}, 32'h0);
        check("rst_req", {10'b0, cop_req_o}, 32'h0);
        check("rst_resp", x_compressed_resp_o.instr, 32'h0);
        do_reset();

        // Decoder0 accepts at once; decoder1 also accepts but must be ignored.
        set_dec(2'b11, 32'h00108093, 1'b1, 32'hdeadbeef, 1'b1);
        x_compressed_valid_i = 1'b1;
        tick();
        check("t1_c1_valid", {30'b0, cop_valid_o}, 32'h1);
        check("t1_c1_ready", {31'b0, x_compressed_ready_o}, 32'h0);
        check("t1_c1_req", {10'b0, cop_req_o}, {10'b0, 16'h0085, 2'b11, 4'h5});
        tick();
        check("t1_c2_ready", {31'b0, x_compressed_ready_o}, 32'h1);
        check("t1_c2_instr", x_compressed_resp_o.instr, 32'h00108093);
        check("t1_c2_accept", {31'b0, x_compressed_resp_o.accept}, 32'h1);
        check("t1_c2_valid", {30'b0, cop_valid_o}, 32'h0);
        x_compressed_valid_i = 1'b0;
        tick();
        check("t1_c3_ready", {31'b0, x_compressed_ready_o}, 32'h0);
        check("t1_c3_resp", x_compressed_resp_o.instr, 32'h0);

        // Decoder0 rejects, decoder1 accepts.
        do_reset();
        set_dec(2'b11, 32'h11111111, 1'b0, 32'h12345678, 1'b1);
        x_compressed_valid_i = 1'b1;
        tick();
        check("t2_c1_valid", {30'b0, cop_valid_o}, 32'h1);
        tick();
        check("t2_c2_valid", {30'b0, cop_valid_o}, 32'h2);
        check("t2_c2_ready", {31'b0, x_compressed_ready_o}, 32'h0);
        tick();
        check("t2_c3_ready", {31'b0, x_compressed_ready_o}, 32'h1);
        check("t2_c3_instr", x_compressed_resp_o.instr, 32'h12345678);
        x_compressed_valid_i = 1'b0;
        tick();

        // Both reject.
        do_reset();
        x_compressed_req_i = '{instr: 16'h4000, mode: 2'b11, id: 4'h1};
        set_dec(2'b11, 32'haaaaaaaa, 1'b0, 32'hbbbbbbbb, 1'b0);
        x_compressed_valid_i = 1'b1;
        tick();
        tick();
        check("t3_c2_ready", {31'b0, x_compressed_ready_o}, 32'h0);
        tick();
        check("t3_c3_ready", {31'b0, x_compressed_ready_o}, 32'h1);
        check("t3_c3_instr", x_compressed_resp_o.instr, 32'h0);
        check("t3_c3_accept", {31'b0, x_compressed_resp_o.accept}, 32'h0);
        x_compressed_valid_i = 1'b0;
        tick();

        // Decoder0 never ready: times out after MaxWait cycles.
        do_reset();
        set_dec(2'b10, 32'h99999999, 1'b1, 32'hcafe0001, 1'b1);
        x_compressed_valid_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t4_c4_valid", {30'b0, cop_valid_o}, 32'h1);
        check("t4_c4_ready", {31'b0, x_compressed_ready_o}, 32'h0);
        tick();
        check("t4_c5_valid", {30'b0, cop_valid_o}, 32'h2);
        tick();
        check("t4_c6_ready", {31'b0, x_compressed_ready_o}, 32'h1);
        check("t4_c6_instr", x_compressed_resp_o.instr, 32'hcafe0001);
        x_compressed_valid_i = 1'b0;
        tick();

        // Flush during PROBE.
        do_reset();
        set_dec(2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
        x_compressed_valid_i = 1'b1;
        tick();
        check("t5_c1_valid", {30'b0, cop_valid_o}, 32'h1);
        x_compressed_valid_i = 1'b0;
        tick();
        check("t5_c2_valid", {30'b0, cop_valid_o}, 32'h0);
        check("t5_c2_ready", {31'b0, x_compressed_ready_o}, 32'h0);
        set_dec(2'b11, 32'h00108093, 1'b1, 32'h0, 1'b0);
        tick();
        tick();
        check("t5_c4_ready", {31'b0, x_compressed_ready_o}, 32'h0);

        // Asynchronous reset mid-PROBE.
        set_dec(2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
        x_compressed_valid_i = 1'b1;
        tick();
        tick();
        check("t6_pre_valid", {30'b0, cop_valid_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", {30'b0, cop_valid_o}, 32'h0);
        check("t6_rst_req", {10'b0, cop_req_o}, 32'h0);
        check("t6_rst_ready", {31'b0, x_compressed_ready_o}, 32'h0);
        x_compressed_valid_i = 1'b0;
        #2;
        rst_ni = 1'b1;
        tick();

        // Decoder1 accepts; valid held high for a back-to-back second request.
        do_reset();
        set_dec(2'b11, 32'h0, 1'b0, 32'h00a00513, 1'b1);
        x_compressed_valid_i = 1'b1;
        tick();
        tick();
        tick();
        check("t7_c3_ready", {31'b0, x_compressed_ready_o}, 32'h1);
        check("t7_c3_instr", x_compressed_resp_o.instr, 32'h00a00513);
        tick();
        check("t7_bubble_valid", {30'b0, cop_valid_o}, 32'h0);
        check("t7_bubble_ready", {31'b0, x_compressed_ready_o}, 32'h0);
        tick();
`ifdef TEST_XIF_COMP_LAST_HIT_EN
        check("t7_second_first", {30'b0, cop_valid_o}, 32'h2);
`else
        check("t7_second_first", {30'b0, cop_valid_o}, 32'h1);
`endif
        x_compressed_valid_i = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_xif_compressed_scheduler.md
Name: test_xif_compressed_scheduler

Overview:
- Sequences one core-side X-IF compressed request across NumCopro downstream compressed decoders.
- Decoders are offered the request one at a time, in order. The first that accepts supplies the decompressed instruction; if all reject, the core receives accept=0.
- Sits between the Ibex X-IF compressed port and the simple_system test coprocessors, so several pseudo decoders can share the single core port.

Parameters:
- NumCopro, 2, number of downstream decoders (1..8).
- MaxWait, 4, cycles to wait for a decoder's ready before treating it as a reject (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- x_compressed_valid_i  in  1  core request valid.
- x_compressed_ready_o  out  1  core request complete; response valid this cycle.
- x_compressed_req_i  in  x_compressed_req_t  instr/mode/id from core.
- x_compressed_resp_o  out  x_compressed_resp_t  registered instr/accept to core.
- cop_valid_o  out  NumCopro  one-hot request valid to decoder i.
- cop_ready_i  in  NumCopro  decoder i ready.
- cop_req_o  out  x_compressed_req_t  registered request, broadcast to all decoders.
- cop_resp_i  in  NumCopro x x_compressed_resp_t  decoder responses.

Behaviour:
- Reset: state=IDLE, idx=0, wait_cnt=0, req/resp registers=0. All outputs 0.
- FSM states: IDLE, PROBE, RESP.
- IDLE:
  - On x_compressed_valid_i, capture x_compressed_req_i into req_q, set idx=start index (0 unless the optional feature is enabled), clear wait_cnt, go to PROBE.
  - No outputs are asserted in IDLE.
- PROBE:
  - cop_valid_o = 1 << idx; cop_req_o = req_q.
  - If cop_ready_i[idx] and cop_resp_i[idx].accept: latch that resp, go to RESP.
  - If cop_ready_i[idx] and not accept, or wait_cnt == MaxWait-1: the decoder has rejected. Advance idx modulo NumCopro and clear wait_cnt.
  - If all NumCopro decoders have rejected: latch resp={instr:0, accept:0}, go to RESP.
  - Otherwise wait_cnt increments each cycle.
  - A probed-decoder counter (width $clog2(NumCopro+1)) tracks exhaustion, independent of wrap-around.
- RESP:
  - x_compressed_ready_o=1 for exactly one cycle; x_compressed_resp_o holds the latched value. Go to IDLE.
  - x_compressed_resp_o is 0 outside RESP.
- Latency:
  - valid at cycle 0 -> ready at cycle 2 when the first decoder accepts with ready=1.
  - Each additional decoder probed adds 1 cycle; each wait cycle adds 1.
  - Worst case is 2 + NumCopro*MaxWait - 1 cycles after cycle 0.
- Flush: if x_compressed_valid_i deasserts while in PROBE, abort. Go to IDLE next cycle, drop cop_valid_o, and do not assert ready.
- Back-to-back requests: valid held high in RESP is treated as the next request only after IDLE (one bubble cycle). Requests are never accepted in RESP.
- Simultaneous events: only cop_ready_i[idx] is observed. Ready/resp from non-selected decoders are ignored.
- Reset mid-operation returns to IDLE asynchronously with all outputs 0.

Optional Feature:
- Macro TEST_XIF_COMP_LAST_HIT_EN.
- Defined:
  - A register last_hit_q (reset 0) stores the idx of the most recent accepting decoder.
  - Probing starts at last_hit_q and wraps modulo NumCopro, still probing every decoder once.
  - An all-reject outcome leaves last_hit_q unchanged.
- Undefined: probing always starts at index 0, and last_hit_q does not exist.

Decomposition:
- Shared package test_xif_pkg holds:
  - typedef enum logic [1:0] {IDLE, PROBE, RESP} xif_sched_state_e;
  - CoproIdxW = $clog2(NumCopro) as a localparam helper function.
- Reuse x_compressed_req_t/x_compressed_resp_t from ibex_pkg.
- One sub-module, test_xif_wait_timer: a saturating counter with clear/enable and an expired flag at MaxWait-1.

Test Plan:
- NumCopro=2, both decoders always ready.
  - Decoder0 accepts 16'h0085 -> ready at cycle 2, resp.instr=32'h00108093, accept=1.
  - cop_valid_o=2'b01 only in cycle 1.
- Decoder0 rejects and decoder1 accepts -> cop_valid_o sequence 01, 10; ready at cycle 3 with decoder1's instr.
- Both reject 16'h4000 -> ready at cycle 3, resp={0,0}.
- Decoder0 ready stuck low with MaxWait=4 -> timeout after 4 cycles, then decoder1 probed; ready at cycle 6.
- Valid drops during PROBE at cycle 1 -> IDLE at cycle 2, ready never asserted. Asynchronous reset asserted mid-PROBE -> all outputs 0 immediately.
- With TEST_XIF_COMP_LAST_HIT_EN: decoder1 accepts the first request -> the second request probes decoder1 first (cop_valid_o=2'b10 in its cycle 1). Without the macro it probes 2'b01 first.
